axis_mem_packer: RTL and testbench

Parametrised AXI4-Stream to packet-memory word packer for the SRAM output-queue datapath. Accepts NetFPGA-style stream beats (tdata/tstrb/tuser/tlast) and emits, per packet, one header word carrying tuser followed by data words of MEM_DATA_W payload bits, each tagged with byte count, word kind and last flag. It also decodes the destination output-queue bitmap from tuser. It sits between the input arbiter and the memory write FIFO, in a single clock domain.

---
 rtl/axis_mem_packer_if.sv | 32 +++
 rtl/axis_mem_packer.sv | 216 +++++++++++++++++++++
 tb/tb_axis_mem_packer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_mem_packer_if.sv
// Stream-in / memory-word-out bundle for axis_mem_packer.
// slave is the packer's view; master is the arbiter/FIFO side that surrounds it.
interface axis_mem_packer_if #(
    parameter int DATA_W     = 256,
    parameter int MEM_DATA_W = 128,
    parameter int USER_W     = 128,
    parameter int NUM_QUEUES = 5
);
    localparam int CNT_W = $clog2(MEM_DATA_W / 8) + 1;
    localparam int MEM_W = MEM_DATA_W + CNT_W + 3;

    logic                  s_tvalid;
    logic                  s_tready;
    logic [DATA_W-1:0]     s_tdata;
    logic [DATA_W/8-1:0]   s_tstrb;
    logic [USER_W-1:0]     s_tuser;
    logic                  s_tlast;
    logic                  m_valid;
    logic                  m_ready;
    logic [MEM_W-1:0]      m_data;
    logic [NUM_QUEUES-1:0] oq;

    modport slave (
        input  s_tvalid, s_tdata, s_tstrb, s_tuser, s_tlast, m_ready,
        output s_tready, m_valid, m_data, oq
    );

    modport master (
        output s_tvalid, s_tdata, s_tstrb, s_tuser, s_tlast, m_ready,
        input  s_tready, m_valid, m_data, oq
    );
endinterface

// File: rtl/axis_mem_packer.sv
// Packs AXI4-Stream beats into header + data memory words with byte counts and oq bitmap.
// Optional AXIS_MEM_PACKER_STATS_EN adds pkt_cnt/word_cnt outputs.
module axis_mem_packer #(
    parameter int DATA_W     = 256,
    parameter int MEM_DATA_W = 128,
    parameter int USER_W     = 128,
    parameter int NUM_QUEUES = 5,
    parameter int DST_LSB    = 24
) (
    input  logic             clk,
    input  logic             reset,
    axis_mem_packer_if.slave bus
`ifdef AXIS_MEM_PACKER_STATS_EN
    ,
    output logic [31:0]      pkt_cnt,
    output logic [31:0]      word_cnt
`endif
);
    localparam int RATIO   = DATA_W / MEM_DATA_W;
    localparam int STRB_W  = DATA_W / 8;
    localparam int CHUNK_B = MEM_DATA_W / 8;
    localparam int CNT_W   = $clog2(CHUNK_B) + 1;
    localparam int MEM_W   = MEM_DATA_W + CNT_W + 3;
    localparam int IDX_W   = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DATA
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_W-1:0]     r_beat;
    logic [STRB_W-1:0]     r_strb;
    logic                  r_last;
    logic                  r_full;
    logic [IDX_W-1:0]      r_idx;
    logic [USER_W-1:0]     r_user;
    logic [NUM_QUEUES-1:0] r_oq;

    logic                  w_full_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic                  w_load;
    logic                  w_new_pkt;
    logic                  w_s_tready;
    logic                  w_m_valid;
    logic [MEM_W-1:0]      w_m_data;

    logic [RATIO-1:0]      w_chunk_nz;
    logic [IDX_W-1:0]      w_next_idx;
    logic                  w_final;
    logic                  w_sop;
    logic [MEM_DATA_W-1:0] w_hdr;
    logic [MEM_DATA_W-1:0] w_payload;
    logic [CNT_W-1:0]      w_nbytes;

    generate
        if (USER_W >= MEM_DATA_W) begin : g_hdr_trunc
            assign w_hdr = r_user[MEM_DATA_W-1:0];
        end else begin : g_hdr_ext
            assign w_hdr = {{(MEM_DATA_W-USER_W){1'b0}}, r_user};
        end
    endgenerate

    always_comb begin
        w_chunk_nz = '0;
        for (int unsigned j = 0; j < RATIO; j++) begin
            w_chunk_nz[j] = |r_strb[j*CHUNK_B +: CHUNK_B];
        end
    end

    // Scan downward so the lowest populated chunk above r_idx wins; none left means final.
    always_comb begin
        w_next_idx = r_idx;
        w_final    = 1'b1;
        for (int unsigned k = 0; k < RATIO; k++) begin
            if ((IDX_W'(RATIO - 1 - k) > r_idx) && w_chunk_nz[RATIO-1-k]) begin
                w_next_idx = IDX_W'(RATIO - 1 - k);
                w_final    = 1'b0;
            end
        end
    end

    assign w_payload = r_beat[int'(r_idx)*MEM_DATA_W +: MEM_DATA_W];
    assign w_nbytes  = CNT_W'($countones(r_strb[int'(r_idx)*CHUNK_B +: CHUNK_B]));

    // Next accepted beat opens a new packet when nothing is held or the held beat closes one.
    assign w_sop = (r_state == ST_IDLE) || ((r_state == ST_DATA) && r_last);

    always_comb begin
        w_state_nxt = r_state;
        w_full_nxt  = r_full;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        w_new_pkt   = 1'b0;
        w_s_tready  = ~r_full;
        w_m_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.s_tvalid) begin
                    w_load      = 1'b1;
                    w_new_pkt   = w_sop;
                    w_full_nxt  = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_HEADER;
                end
            end
            ST_HEADER: begin
                w_m_valid = 1'b1;
                if (bus.m_ready) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_full) begin
                    w_m_valid = 1'b1;
                    if (bus.m_ready) begin
                        if (w_final) begin
                            w_s_tready = 1'b1;
                            w_idx_nxt  = '0;
                            if (bus.s_tvalid) begin
                                w_load     = 1'b1;
                                w_full_nxt = 1'b1;
                                if (r_last) begin
                                    w_new_pkt   = w_sop;
                                    w_state_nxt = ST_HEADER;
                                end
                            end else begin
                                w_full_nxt = 1'b0;
                                if (r_last) begin
                                    w_state_nxt = ST_IDLE;
                                end
                            end
                        end else begin
                            w_idx_nxt = w_next_idx;
                        end
                    end
                end else if (bus.s_tvalid) begin
                    w_load     = 1'b1;
                    w_full_nxt = 1'b1;
                    w_idx_nxt  = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_full_nxt  = 1'b0;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_m_data = '0;
        if (r_state == ST_HEADER) begin
            w_m_data = {w_hdr, {CNT_W{1'b0}}, 2'b00, 1'b0};
        end else if ((r_state == ST_DATA) && r_full) begin
            w_m_data = {w_payload, w_nbytes, 2'b01, r_last & w_final};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_full  <= 1'b0;
            r_idx   <= '0;
            r_beat  <= '0;
            r_strb  <= '0;
            r_last  <= 1'b0;
            r_user  <= '0;
            r_oq    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_full  <= w_full_nxt;
            r_idx   <= w_idx_nxt;
            if (w_load) begin
                r_beat <= bus.s_tdata;
                r_strb <= bus.s_tstrb;
                r_last <= bus.s_tlast;
            end
            if (w_new_pkt) begin
                r_user <= bus.s_tuser;
                r_oq   <= bus.s_tuser[DST_LSB +: NUM_QUEUES];
            end
        end
    end

    assign bus.s_tready = w_s_tready & ~reset;
    assign bus.m_valid  = w_m_valid;
    assign bus.m_data   = w_m_data;
    assign bus.oq       = r_oq;

`ifdef AXIS_MEM_PACKER_STATS_EN
    logic        w_xfer;
    logic [31:0] r_pkt_cnt;
    logic [31:0] r_word_cnt;

    assign w_xfer = w_m_valid & bus.m_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pkt_cnt  <= '0;
            r_word_cnt <= '0;
        end else if (w_xfer) begin
            r_word_cnt <= r_word_cnt + 32'd1;
            if (w_m_data[0]) begin
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end
        end
    end

    assign pkt_cnt  = r_pkt_cnt;
    assign word_cnt = r_word_cnt;
`endif
endmodule

// File: tb/tb_axis_mem_packer.sv
// Scoreboard bench for axis_mem_packer; stats checks compile in with AXIS_MEM_PACKER_STATS_EN.
module tb_axis_mem_packer;
    localparam int DATA_W     = 256;
    localparam int MEM_DATA_W = 128;
    localparam int USER_W     = 128;
    localparam int NUM_QUEUES = 5;
    localparam int DST_LSB    = 24;
    localparam int STRB_W     = DATA_W / 8;
    localparam int RATIO      = DATA_W / MEM_DATA_W;
    localparam int CB         = MEM_DATA_W / 8;
    localparam int CNT_W      = $clog2(CB) + 1;
    localparam int MEM_W      = MEM_DATA_W + CNT_W + 3;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic [USER_W-1:0] user;
        logic              last;
    } beat_t;

    typedef struct {
        logic [MEM_W-1:0]      word;
        logic [NUM_QUEUES-1:0] oq;
    } exp_t;

    beat_t q_beats[$];
    exp_t  q_exp[$];
    int    checks   = 0;
    int    failures = 0;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    axis_mem_packer_if #(
        .DATA_W    (DATA_W),
        .MEM_DATA_W(MEM_DATA_W),
        .USER_W    (USER_W),
        .NUM_QUEUES(NUM_QUEUES)
    ) bus ();

`ifdef AXIS_MEM_PACKER_STATS_EN
    logic [31:0] pkt_cnt;
    logic [31:0] word_cnt;
`endif

    axis_mem_packer #(
        .DATA_W    (DATA_W),
        .MEM_DATA_W(MEM_DATA_W),
        .USER_W    (USER_W),
        .NUM_QUEUES(NUM_QUEUES),
        .DST_LSB   (DST_LSB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus)
`ifdef AXIS_MEM_PACKER_STATS_EN
        ,
        .pkt_cnt (pkt_cnt),
        .word_cnt(word_cnt)
`endif
    );

    // Reference model: queue the beats and the words they must produce.
    task automatic push_packet(input int nbeats, input logic [DATA_W-1:0] base,
                               input logic [STRB_W-1:0] last_strb, input logic [USER_W-1:0] user);
        beat_t         b;
        exp_t          e;
        int            em[$];
        logic [CB-1:0] s;
        int            n;
        e.word = {user[MEM_DATA_W-1:0], {CNT_W{1'b0}}, 2'b00, 1'b0};
        e.oq   = user[DST_LSB +: NUM_QUEUES];
        q_exp.push_back(e);
        for (int k = 0; k < nbeats; k++) begin
            b.data = base + DATA_W'(k);
            b.strb = (k == nbeats - 1) ? last_strb : {STRB_W{1'b1}};
            b.user = (k == 0) ? user : ~user;
            b.last = (k == nbeats - 1);
            q_beats.push_back(b);
            em.delete();
            for (int c = 0; c < RATIO; c++) begin
                s = b.strb[c*CB +: CB];
                if (c == 0 || s != '0) em.push_back(c);
            end
            for (int i = 0; i < em.size(); i++) begin
                s = b.strb[em[i]*CB +: CB];
                n = 0;
                for (int t = 0; t < CB; t++) n += int'(s[t]);
                e.word = {b.data[em[i]*MEM_DATA_W +: MEM_DATA_W], CNT_W'(n), 2'b01,
                          b.last && (i == em.size() - 1)};
                q_exp.push_back(e);
            end
        end
    endtask

    task automatic drive(input logic rdy);
        @(negedge clk);
        bus.m_ready = rdy;
        if (q_beats.size() > 0) begin
            bus.s_tvalid = 1'b1;
            bus.s_tdata  = q_beats[0].data;
            bus.s_tstrb  = q_beats[0].strb;
            bus.s_tuser  = q_beats[0].user;
            bus.s_tlast  = q_beats[0].last;
        end else begin
            bus.s_tvalid = 1'b0;
        end
        #1;
    endtask

    task automatic take_beat();
        if (bus.s_tvalid && bus.s_tready && q_beats.size() > 0) q_beats.delete(0);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.s_tstrb  = '0;
        bus.s_tuser  = '0;
        bus.s_tlast  = 1'b0;
        bus.m_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus.s_tready !== 1'b0 || bus.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: tready=%b valid=%b required 0 0", bus.s_tready, bus.m_valid);
        end
        checks++;
        if (bus.m_data !== '0 || bus.oq !== '0) begin
            failures++;
            $display("FAIL reset_outputs: m_data=%h oq=%b required zero", bus.m_data, bus.oq);
        end
`ifdef AXIS_MEM_PACKER_STATS_EN
        checks++;
        if (pkt_cnt !== 32'd0 || word_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_stats: pkt=%0d word=%0d required 0 0", pkt_cnt, word_cnt);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.s_tready !== 1'b1 || bus.m_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: tready=%b valid=%b required 1 0", bus.s_tready, bus.m_valid);
        end
    endtask

    task automatic test_single_beat();
        exp_t e;
        int   cyc = 0, acc_cyc = -1, first_cyc = -1, nwords = 0;
        push_packet(1, DATA_W'(50), {STRB_W{1'b1}}, USER_W'(32'hAF00_0000));
        while ((q_beats.size() > 0 || q_exp.size() > 0) && cyc < 50) begin
            drive(1'b1);
            if (bus.s_tvalid && bus.s_tready && acc_cyc < 0) acc_cyc = cyc;
            take_beat();
            if (bus.m_valid && bus.m_ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                nwords++;
                checks++;
                if (q_exp.size() == 0) begin
                    failures++;
                    $display("FAIL single_extra: got %h required no word", bus.m_data);
                end else begin
                    e = q_exp.pop_front();
                    if (bus.m_data !== e.word || bus.oq !== e.oq) begin
                        failures++;
                        $display("FAIL single_word%0d: got %h oq %b required %h oq %b",
                                 nwords, bus.m_data, bus.oq, e.word, e.oq);
                    end
                end
            end
            cyc++;
        end
        checks++;
        if (q_exp.size() != 0 || q_beats.size() != 0) begin
            failures++;
            $display("FAIL single_timeout: words left %0d required 0", q_exp.size());
        end
        checks++;
        if (first_cyc - acc_cyc != 1 || nwords != 3) begin
            failures++;
            $display("FAIL single_latency: latency %0d words %0d required 1 3", first_cyc - acc_cyc, nwords);
        end
        checks++;
        if (bus.oq !== 5'b01111) begin
            failures++;
            $display("FAIL single_oq: got %b required 01111", bus.oq);
        end
    endtask

    task automatic test_long_packet();
        exp_t             e;
        logic [MEM_W-1:0] last_word = '0;
        int               cyc = 0, first_cyc = -1, last_cyc = -1, nwords = 0;
        push_packet(51, DATA_W'(200), STRB_W'(32'h0000_000F), USER_W'(32'h5500_0000));
        while ((q_beats.size() > 0 || q_exp.size() > 0) && cyc < 400) begin
            drive(1'b1);
            take_beat();
            if (bus.m_valid && bus.m_ready) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc  = cyc;
                last_word = bus.m_data;
                nwords++;
                checks++;
                if (q_exp.size() == 0) begin
                    failures++;
                    $display("FAIL long_extra: got %h required no word", bus.m_data);
                end else begin
                    e = q_exp.pop_front();
                    if (bus.m_data !== e.word || bus.oq !== e.oq) begin
                        failures++;
                        $display("FAIL long_word%0d: got %h required %h", nwords, bus.m_data, e.word);
                    end
                end
            end
            cyc++;
        end
        checks++;
        if (nwords != 102 || last_cyc - first_cyc != 101) begin
            failures++;
            $display("FAIL long_count: words %0d span %0d required 102 101", nwords, last_cyc - first_cyc);
        end
        checks++;
        if (last_word[CNT_W+2:3] !== CNT_W'(4) || last_word[0] !== 1'b1) begin
            failures++;
            $display("FAIL long_final: nbytes %0d last %b required 4 1", last_word[CNT_W+2:3], last_word[0]);
        end
    endtask

    task automatic test_backpressure();
        exp_t             e;
        logic [MEM_W-1:0] prev_d = '0;
        logic             prev_hold = 1'b0;
        logic             rdy;
        int               cyc = 0, nhdr = 0;
        push_packet(2, DATA_W'(32'h1234), {STRB_W{1'b1}}, USER_W'(32'h3300_0000));
        while ((q_beats.size() > 0 || q_exp.size() > 0) && cyc < 200) begin
            if (cyc == 0 || cyc == 3) rdy = 1'b1;
            else if (cyc < 3) rdy = 1'b0;
            else rdy = 1'($urandom_range(0, 1));
            drive(rdy);
            take_beat();
            if (prev_hold) begin
                checks++;
                if (bus.m_valid !== 1'b1 || bus.m_data !== prev_d) begin
                    failures++;
                    $display("FAIL bp_hold: valid %b data %h required 1 %h", bus.m_valid, bus.m_data, prev_d);
                end
            end
            prev_hold = bus.m_valid && !bus.m_ready;
            prev_d    = bus.m_data;
            if (bus.m_valid && bus.m_ready) begin
                if (bus.m_data[2:1] == 2'b00) nhdr++;
                checks++;
                if (q_exp.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra: got %h required no word", bus.m_data);
                end else begin
                    e = q_exp.pop_front();
                    if (bus.m_data !== e.word || bus.oq !== e.oq) begin
                        failures++;
                        $display("FAIL bp_word: got %h required %h", bus.m_data, e.word);
                    end
                end
            end
            cyc++;
        end
        checks++;
        if (q_exp.size() != 0 || nhdr != 1) begin
            failures++;
            $display("FAIL bp_complete: left %0d headers %0d required 0 1", q_exp.size(), nhdr);
        end
    endtask

    task automatic test_back_to_back();
        exp_t                  e;
        int                    wcyc[$];
        logic [NUM_QUEUES-1:0] woq[$];
        logic [1:0]            wkind[$];
        int                    cyc = 0;
`ifdef AXIS_MEM_PACKER_STATS_EN
        logic [31:0] pkt0  = pkt_cnt;
        logic [31:0] word0 = word_cnt;
`endif
        push_packet(2, DATA_W'(32'h10), {STRB_W{1'b1}}, USER_W'(32'hAF00_0000));
        push_packet(1, DATA_W'(32'h99), STRB_W'(32'h000F_FFFF), USER_W'(32'hEA00_0000));
        while ((q_beats.size() > 0 || q_exp.size() > 0) && cyc < 100) begin
            drive(1'b1);
            take_beat();
            if (bus.m_valid && bus.m_ready) begin
                wcyc.push_back(cyc);
                woq.push_back(bus.oq);
                wkind.push_back(bus.m_data[2:1]);
                checks++;
                if (q_exp.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra: got %h required no word", bus.m_data);
                end else begin
                    e = q_exp.pop_front();
                    if (bus.m_data !== e.word || bus.oq !== e.oq) begin
                        failures++;
                        $display("FAIL b2b_word%0d: got %h oq %b required %h oq %b",
                                 wcyc.size(), bus.m_data, bus.oq, e.word, e.oq);
                    end
                end
            end
            cyc++;
        end
        checks++;
        if (wcyc.size() != 8) begin
            failures++;
            $display("FAIL b2b_count: words %0d required 8", wcyc.size());
        end else begin
            checks++;
            if (wcyc[5] != wcyc[4] + 1 || wkind[5] !== 2'b00) begin
                failures++;
                $display("FAIL b2b_gap: header at %0d kind %b after last at %0d required next cycle kind 00",
                         wcyc[5], wkind[5], wcyc[4]);
            end
            checks++;
            if (woq[4] !== 5'b01111 || woq[5] !== 5'b01010) begin
                failures++;
                $display("FAIL b2b_oq: got %b then %b required 01111 then 01010", woq[4], woq[5]);
            end
        end
`ifdef AXIS_MEM_PACKER_STATS_EN
        @(negedge clk);
        bus.s_tvalid = 1'b0;
        #1;
        checks++;
        if (pkt_cnt - pkt0 !== 32'd2 || word_cnt - word0 !== 32'(wcyc.size())) begin
            failures++;
            $display("FAIL b2b_stats: pkt +%0d word +%0d required +2 +%0d",
                     pkt_cnt - pkt0, word_cnt - word0, wcyc.size());
        end
`endif
    endtask

    task automatic test_reset_mid_packet();
        exp_t e;
        int   cyc = 0, ndata = 0, nwords = 0;
        push_packet(3, DATA_W'(32'h500), {STRB_W{1'b1}}, USER_W'(32'h1100_0000));
        while (ndata < 3 && cyc < 50) begin
            drive(1'b1);
            take_beat();
            if (bus.m_valid && bus.m_ready) begin
                if (bus.m_data[2:1] == 2'b01) ndata++;
                checks++;
                e = q_exp.pop_front();
                if (bus.m_data !== e.word) begin
                    failures++;
                    $display("FAIL rst_pre_word: got %h required %h", bus.m_data, e.word);
                end
            end
            cyc++;
        end
        @(negedge clk);
        reset        = 1'b1;
        bus.s_tvalid = 1'b0;
        bus.m_ready  = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (bus.m_valid !== 1'b0 || bus.oq !== '0 || bus.s_tready !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: valid %b oq %b tready %b required 0 00000 0",
                     bus.m_valid, bus.oq, bus.s_tready);
        end
        q_beats.delete();
        q_exp.delete();
        reset = 1'b0;
        push_packet(1, DATA_W'(32'h777), STRB_W'(32'h0000_FFFF), USER_W'(32'h0400_0000));
        cyc = 0;
        while ((q_beats.size() > 0 || q_exp.size() > 0) && cyc < 50) begin
            drive(1'b1);
            take_beat();
            if (bus.m_valid && bus.m_ready) begin
                nwords++;
                checks++;
                if (q_exp.size() == 0) begin
                    failures++;
                    $display("FAIL rst_post_extra: got %h required no word", bus.m_data);
                end else begin
                    e = q_exp.pop_front();
                    if (bus.m_data !== e.word || bus.oq !== e.oq) begin
                        failures++;
                        $display("FAIL rst_post_word%0d: got %h oq %b required %h oq %b",
                                 nwords, bus.m_data, bus.oq, e.word, e.oq);
                    end
                end
            end
            cyc++;
        end
        checks++;
        if (nwords != 2 || q_exp.size() != 0) begin
            failures++;
            $display("FAIL rst_post_count: words %0d left %0d required 2 0", nwords, q_exp.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_beat();
        test_long_packet();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
